// File: rtl/rr_iter_multiplier_if.sv
// rtl/rr_iter_multiplier_if.sv - operand/result handshake bundle for rr_iter_multiplier
interface rr_iter_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 approx_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/rr_iter_multiplier.sv
// rtl/rr_iter_multiplier.sv - sequential quadrant-split multiplier, one half-width product per cycle
// Optional completed-operation counter port enabled by RR_OP_COUNT_EN.
module rr_iter_multiplier #(
  parameter int WIDTH      = 16,
  parameter int APPROX_LSB = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_iter_multiplier_if.slave bus
`ifdef RR_OP_COUNT_EN
  ,
  output logic [15:0]         op_count
`endif
);
  localparam int H = WIDTH / 2;
  // Mask kept on LL in approximate mode; a shift of WIDTH clears every bit.
  localparam logic [WIDTH-1:0] LL_KEEP =
    {WIDTH{1'b1}} << ((APPROX_LSB >= WIDTH) ? WIDTH : APPROX_LSB);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           phase;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 approx_q;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   p_q;
  logic                 accept;
  logic                 handoff;
  logic [H-1:0]         mul_x;
  logic [H-1:0]         mul_y;
  logic [WIDTH-1:0]     mul_p;
  logic [2*WIDTH-1:0]   term;

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    handoff       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (phase == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          handoff = 1'b1;
          // Handoff cycle doubles as an accept slot for the next operation.
          if (bus.in_valid) begin
            accept    = 1'b1;
            state_nxt = MUL;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_x = a_q[H-1:0];
    mul_y = b_q[H-1:0];
    case (phase)
      2'd1: mul_x = a_q[WIDTH-1:H];
      2'd2: mul_y = b_q[WIDTH-1:H];
      2'd3: begin
        mul_x = a_q[WIDTH-1:H];
        mul_y = b_q[WIDTH-1:H];
      end
      default: ;
    endcase
    mul_p = WIDTH'(mul_x) * WIDTH'(mul_y);
    case (phase)
      2'd0:    term = {{WIDTH{1'b0}}, (approx_q ? (mul_p & LL_KEEP) : mul_p)};
      2'd3:    term = {mul_p, {WIDTH{1'b0}}};
      default: term = (2*WIDTH)'(mul_p) << H;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc      <= '0;
      p_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        approx_q <= bus.approx_en;
        acc      <= '0;
        phase    <= 2'd0;
      end else if (state == MUL) begin
        acc   <= acc + term;
        phase <= phase + 2'd1;
        if (phase == 2'd3) p_q <= acc + term;
      end
    end
  end

  assign bus.p = p_q;

`ifdef RR_OP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)          op_count <= 16'd0;
    else if (handoff) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rr_iter_multiplier.sv
// tb/tb_rr_iter_multiplier.sv - directed vector bench for rr_iter_multiplier
module tb_rr_iter_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ops_done = 0;

  rr_iter_multiplier_if #(.WIDTH(16)) if16 ();
  rr_iter_multiplier_if #(.WIDTH(8))  if8 ();
`ifdef RR_OP_COUNT_EN
  logic [15:0] op_count16;
  logic [15:0] op_count8;
`endif

  rr_iter_multiplier #(.WIDTH(16), .APPROX_LSB(4)) u_dut (
    .clk(clk), .rst(rst), .bus(if16)
`ifdef RR_OP_COUNT_EN
    , .op_count(op_count16)
`endif
  );

  rr_iter_multiplier #(.WIDTH(8), .APPROX_LSB(4)) u_dut8 (
    .clk(clk), .rst(rst), .bus(if8)
`ifdef RR_OP_COUNT_EN
    , .op_count(op_count8)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        approx;
    logic [31:0] exp_p;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid16(output int lat);
    lat = 0;
    while (!if16.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_b, input logic tap,
                       input logic [31:0] texp, input string nm);
    int lat;
    if16.a = ta; if16.b = tb_b; if16.approx_en = tap; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.a = 16'hDEAD; if16.b = 16'hBEEF; if16.approx_en = ~tap;
    wait_valid16(lat);
    chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " p"}, 64'(if16.p), 64'(texp));
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    ops_done++;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_b);
    int lat;
    if8.a = ta; if8.b = tb_b; if8.approx_en = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("w8 %0h*%0h", ta, tb_b), 64'(if8.p), 64'(16'(ta) * 16'(tb_b)));
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] held;
    int bl[10];

    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0000};
    vecs[2]  = '{16'h1234, 16'h0056, 1'b1, 32'h00061D70};
    vecs[3]  = '{16'h1234, 16'h0056, 1'b0, 32'h00061D78};
    vecs[4]  = '{16'h0000, 16'h0000, 1'b0, 32'h00000000};
    vecs[5]  = '{16'hFFFF, 16'h0000, 1'b1, 32'h00000000};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vecs[7]  = '{16'h000F, 16'h0001, 1'b1, 32'h00000000};
    vecs[8]  = '{16'h00FF, 16'h00FF, 1'b1, 32'h0000FE00};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b0, 32'h0C374FA4};
    vecs[10] = '{16'hABCD, 16'h1234, 1'b1, 32'h0C374FA0};
    vecs[11] = '{16'h0100, 16'h0100, 1'b1, 32'h00010000};

    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.approx_en = 1'b0; if16.out_ready = 1'b0;
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.approx_en  = 1'b0; if8.out_ready  = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(if16.in_ready), 64'd1);
    chk("reset out_valid", 64'(if16.out_valid), 64'd0);
    chk("reset p", 64'(if16.p), 64'd0);
`ifdef RR_OP_COUNT_EN
    chk("reset op_count", 64'(op_count16), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].approx, vecs[i].exp_p, $sformatf("vec%0d", i));
    end
    chk("idle in_ready", 64'(if16.in_ready), 64'd1);
    chk("idle p held", 64'(if16.p), 64'(vecs[11].exp_p));

    // Backpressure then back-to-back accept in the handoff cycle.
    if16.a = 16'h1234; if16.b = 16'h0056; if16.approx_en = 1'b0; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    wait_valid16(lat);
    chk("bp latency", 64'(lat), 64'd4);
    held = if16.p;
    chk("bp p", 64'(held), 64'h00061D78);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp p stable", 64'(if16.p), 64'h00061D78);
      chk("bp valid held", 64'(if16.out_valid), 64'd1);
      chk("bp in_ready", 64'(if16.in_ready), 64'd0);
    end
    if16.out_ready = 1'b1; if16.in_valid = 1'b1; if16.a = 16'd3; if16.b = 16'd5;
    #1;
    chk("b2b in_ready", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    ops_done++;
    if16.out_ready = 1'b0; if16.in_valid = 1'b0;
    chk("b2b out_valid drop", 64'(if16.out_valid), 64'd0);
    chk("b2b in_ready busy", 64'(if16.in_ready), 64'd0);
    chk("b2b p kept", 64'(if16.p), 64'h00061D78);
    wait_valid16(lat);
    chk("b2b latency", 64'(lat), 64'd4);
    chk("b2b p", 64'(if16.p), 64'h0000000F);
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    ops_done++;
`ifdef RR_OP_COUNT_EN
    chk("op_count", 64'(op_count16), 64'(ops_done));
`endif

    // Abort during phase 2.
    if16.a = 16'h00FF; if16.b = 16'h00FF; if16.approx_en = 1'b0; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ops_done = 0;
    chk("abort out_valid", 64'(if16.out_valid), 64'd0);
    chk("abort in_ready", 64'(if16.in_ready), 64'd1);
    chk("abort p", 64'(if16.p), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort no result", 64'(if16.out_valid), 64'd0);
    run16(16'd2, 16'd7, 1'b0, 32'd14, "post abort");
`ifdef RR_OP_COUNT_EN
    chk("op_count after abort", 64'(op_count16), 64'(ops_done));
`endif

    bl = '{0, 1, 2, 3, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFE, 8'hFF};
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 10; bi++) begin
        run8(8'(ai), 8'(bl[bi]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
